// File: rtl/conv_bf16tomxint_stream_if.sv
// Valid/ready stream bundle for the BF16 -> MXINT block converter.
// Carries the BF16 input beat (i_valid/o_ready/i_bf16_vec) and the
// quantised output beat (o_valid/i_ready/o_mx_vec/o_mx_exp/o_first).
// Signal names are seen from the converter: i_* are driven into it, o_* are driven by it.
//   master : producer/consumer side (drives i_valid, i_bf16_vec, i_ready)
//   slave  : converter side (drives o_ready, o_valid, o_mx_vec, o_mx_exp, o_first)
interface conv_bf16tomxint_stream_if #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned LANES     = 8
);
    logic                            i_valid;
    logic                            o_ready;
    logic [LANES-1:0][15:0]          i_bf16_vec;
    logic                            o_valid;
    logic                            i_ready;
    logic [LANES-1:0][BIT_WIDTH-1:0] o_mx_vec;
    logic [7:0]                      o_mx_exp;
    logic                            o_first;

    modport master (
        output i_valid, i_bf16_vec, i_ready,
        input  o_ready, o_valid, o_mx_vec, o_mx_exp, o_first
    );

    modport slave (
        input  i_valid, i_bf16_vec, i_ready,
        output o_ready, o_valid, o_mx_vec, o_mx_exp, o_first
    );
endinterface

// File: rtl/conv_bf16tomxint_stream.sv
// Streaming BF16 -> MXINT converter.
// Collects one MX block of k BF16 elements over k/lanes input beats, derives the
// shared E8M0 scale (max biased exponent, 0xFF if the block holds Inf/NaN), then
// emits the quantised block over k/lanes output beats.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous reset, active low
//   bus     : conv_bf16tomxint_stream_if.slave
//             input  side : i_valid, o_ready, i_bf16_vec (lane 0 = lowest block index)
//             output side : o_valid, i_ready, o_mx_vec, o_mx_exp, o_first
// Build option:
//   MX_ROUND_NEAREST_EN : round-to-nearest-even on the shifted-out bits;
//                         when undefined the magnitude is truncated toward zero.
module conv_bf16tomxint_stream #(
    parameter int unsigned bit_width = 8,
    parameter int unsigned k         = 32,
    parameter int unsigned lanes     = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    conv_bf16tomxint_stream_if.slave bus
);

    localparam int unsigned BEATS    = k / lanes;
    localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned RSH      = 9 - bit_width;
    localparam int unsigned MAG_MAX  = (1 << (bit_width - 1)) - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    // Configuration sanity checks
    if ((k % lanes) != 0) begin : g_bad_lanes
        $error("conv_bf16tomxint_stream: k must be a multiple of lanes");
    end
    if ((bit_width < 4) || (bit_width > 8)) begin : g_bad_width
        $error("conv_bf16tomxint_stream: bit_width must be within 4..8");
    end

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

    state_t                         state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [7:0]                     emax_q;
    logic                           nan_q;
    logic                           ready_q;
    logic                           valid_q;
    logic                           first_q;
    logic [7:0]                     exp_q;
    logic [lanes-1:0][bit_width-1:0] vec_q;
    logic [lanes-1:0][15:0]         buf_q [BEATS];

    logic                           in_fire;
    logic                           out_fire;
    logic [7:0]                     in_emax;
    logic                           in_nan;
    logic [7:0]                     emax_merge;
    logic                           nan_merge;
    logic [7:0]                     qmax;
    logic [CNT_W-1:0]               q_idx;
    logic [lanes-1:0][15:0]         q_src;
    logic [lanes-1:0][bit_width-1:0] q_vec;

    // Quantise one BF16 element against the block's max biased exponent
    function automatic logic [bit_width-1:0] quant_elem(input logic [15:0] x,
                                                        input logic [7:0]  emax);
        logic [8:0]           sh;
        logic [8:0]           mag;
        logic [bit_width-1:0] res;
`ifdef MX_ROUND_NEAREST_EN
        logic [23:0]          ext;
`endif
        // emax >= element exponent by construction, so the difference never wraps
        sh  = {1'b0, emax - x[14:7]} + 9'(RSH);
        mag = '0;
        res = '0;
        if ((x[14:7] != 8'h00) && (sh < 9'd16)) begin
`ifdef MX_ROUND_NEAREST_EN
            // Keep 16 bits below the binary point: bit 15 is the half bit, the rest is sticky
            ext = {1'b1, x[6:0], 16'h0000} >> sh[3:0];
            mag = {1'b0, ext[23:16]};
            if (ext[15] && ((|ext[14:0]) || ext[16])) begin
                mag = mag + 9'd1;
            end
`else
            mag = {1'b0, ({1'b1, x[6:0]} >> sh[3:0])};
`endif
            if (mag > 9'(MAG_MAX)) begin
                mag = 9'(MAG_MAX);
            end
            res = bit_width'(mag);
            if (x[15]) begin
                res = ~res + bit_width'(1);
            end
        end
        return res;
    endfunction

    assign in_fire  = bus.i_valid && ready_q;
    assign out_fire = valid_q && bus.i_ready;

    // Exponent max / Inf-NaN detection across the incoming beat, merged with the running values
    always_comb begin
        in_emax = 8'h00;
        in_nan  = 1'b0;
        for (int l = 0; l < int'(lanes); l++) begin
            if (bus.i_bf16_vec[l][14:7] > in_emax) begin
                in_emax = bus.i_bf16_vec[l][14:7];
            end
            if (bus.i_bf16_vec[l][14:7] == 8'hFF) begin
                in_nan = 1'b1;
            end
        end
        emax_merge = (in_emax > emax_q) ? in_emax : emax_q;
        nan_merge  = nan_q | in_nan;
    end

    // Select the beat to quantise next: beat 0 when the last input beat lands,
    // otherwise the beat after the one currently presented.
    always_comb begin
        q_idx = '0;
        if ((state_q == S_EMIT) && (cnt_q != LAST_CNT)) begin
            q_idx = cnt_q + CNT_W'(1);
        end
        // Single-beat blocks: beat 0 is still on the input bus, not yet in the buffer
        if ((state_q == S_COLLECT) && (cnt_q == '0)) begin
            q_src = bus.i_bf16_vec;
        end else begin
            q_src = buf_q[q_idx];
        end
        qmax = (state_q == S_COLLECT) ? emax_merge : emax_q;
        for (int l = 0; l < int'(lanes); l++) begin
            q_vec[l] = quant_elem(q_src[l], qmax);
        end
    end

    // Block buffer (no reset needed: contents are only read after being written)
    always_ff @(posedge i_clk) begin
        if (in_fire) begin
            buf_q[cnt_q] <= bus.i_bf16_vec;
        end
    end

    // Control FSM and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            emax_q  <= 8'h00;
            nan_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            exp_q   <= 8'h00;
            vec_q   <= '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (in_fire) begin
                        emax_q <= emax_merge;
                        nan_q  <= nan_merge;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            state_q <= S_EMIT;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            first_q <= 1'b1;
                            exp_q   <= nan_merge ? 8'hFF : emax_merge;
                            vec_q   <= q_vec;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (out_fire) begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            state_q <= S_COLLECT;
                            emax_q  <= 8'h00;
                            nan_q   <= 1'b0;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            first_q <= 1'b0;
                            exp_q   <= 8'h00;
                            vec_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            first_q <= 1'b0;
                            vec_q   <= q_vec;
                        end
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_first  = first_q;
    assign bus.o_mx_exp = exp_q;
    assign bus.o_mx_vec = vec_q;

endmodule

// File: tb/tb_conv_bf16tomxint_stream.sv
// Bench for conv_bf16tomxint_stream (bit_width=8, k=32, lanes=8).
module tb_conv_bf16tomxint_stream;

    localparam int BW    = 8;
    localparam int K     = 32;
    localparam int LANES = 8;
    localparam int BEATS = K / LANES;

`ifdef MX_ROUND_NEAREST_EN
    localparam logic [7:0] R_P15 = 8'h02;   // +1.5 at shift 7
    localparam logic [7:0] R_N15 = 8'hFE;   // -1.5 at shift 7
    localparam logic [7:0] R_P35 = 8'h04;   // +3.5 at shift 6
`else
    localparam logic [7:0] R_P15 = 8'h01;
    localparam logic [7:0] R_N15 = 8'hFF;
    localparam logic [7:0] R_P35 = 8'h03;
`endif

    typedef struct {
        logic [15:0] fill;
        logic [15:0] s0;
        int          i0;
        logic [15:0] s1;
        int          i1;
        logic [7:0]  x_exp;
        logic [7:0]  x_fill;
        logic [7:0]  x_s0;
        logic [7:0]  x_s1;
        bit          chk;
    } vec_t;

    typedef struct {
        logic [LANES-1:0][BW-1:0] vec;
        logic [7:0]               exp;
        logic                     first;
        bit                       chk;
    } beat_t;

    logic clk;
    logic rst_n;
    logic rdy_rand  = 1'b1;
    logic stall_req = 1'b0;
    bit   rand_mode = 1'b0;

    int checks = 0;
    int errors = 0;
    int stall_seen = 0;

    logic [15:0] cur_blk [K];
    vec_t        tbl [13];
    beat_t       sb [$];

    conv_bf16tomxint_stream_if #(.BIT_WIDTH(BW), .LANES(LANES)) bus ();

    conv_bf16tomxint_stream #(.bit_width(BW), .k(K), .lanes(LANES)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.i_ready = rdy_rand && !stall_req;

    always @(posedge clk) begin
        #1;
        rdy_rand = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Independent reference: real-valued scaling, then floor or round-half-even
    function automatic logic [7:0] model_elem(input logic [15:0] x, input int emax);
        int  e;
        int  q;
        real r;
        real fl;
        e = int'(x[14:7]);
        if (e == 0) return 8'h00;
        r  = real'(128 + int'(x[6:0])) / (2.0 ** real'(emax - e + 9 - BW));
        fl = $floor(r);
`ifdef MX_ROUND_NEAREST_EN
        if ((r - fl > 0.5) || ((r - fl == 0.5) && (($rtoi(fl) % 2) == 1))) fl = fl + 1.0;
`endif
        q = $rtoi(fl);
        if (q > 127) q = 127;
        if (x[15]) q = -q;
        return 8'(q);
    endfunction

    task automatic push_model();
        int    emax;
        bit    nan;
        beat_t it;
        emax = 0;
        nan  = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (int'(cur_blk[j][14:7]) > emax) emax = int'(cur_blk[j][14:7]);
            if (cur_blk[j][14:7] == 8'hFF) nan = 1'b1;
        end
        for (int b = 0; b < BEATS; b++) begin
            it.first = (b == 0);
            it.exp   = nan ? 8'hFF : 8'(emax);
            it.chk   = 1'b1;
            for (int l = 0; l < LANES; l++) it.vec[l] = model_elem(cur_blk[b*LANES+l], emax);
            sb.push_back(it);
        end
    endtask

    task automatic load_table(input int n);
        beat_t it;
        for (int j = 0; j < K; j++) begin
            cur_blk[j] = tbl[n].fill;
            if (j == tbl[n].i0) cur_blk[j] = tbl[n].s0;
            if (j == tbl[n].i1) cur_blk[j] = tbl[n].s1;
        end
        for (int b = 0; b < BEATS; b++) begin
            it.first = (b == 0);
            it.exp   = tbl[n].x_exp;
            it.chk   = tbl[n].chk;
            for (int l = 0; l < LANES; l++) begin
                it.vec[l] = tbl[n].x_fill;
                if (b*LANES+l == tbl[n].i0) it.vec[l] = tbl[n].x_s0;
                if (b*LANES+l == tbl[n].i1) it.vec[l] = tbl[n].x_s1;
            end
            sb.push_back(it);
        end
    endtask

    // Drive n beats of cur_blk; optionally check first-output latency after the last beat
    task automatic send_beats(input int n, input bit chk_lat);
        int guard;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            for (int l = 0; l < LANES; l++) bus.i_bf16_vec[l] = cur_blk[b*LANES+l];
            guard = 0;
            while (!bus.o_ready) begin
                @(negedge clk);
                guard++;
                if (guard > 1000) begin
                    errors++;
                    $display("FAIL input_timeout: o_ready stuck at %b, expected 1", bus.o_ready);
                    $fatal(1, "input handshake timeout");
                end
            end
        end
        @(negedge clk);
        if (chk_lat) begin
            chk("latency_valid", 64'(bus.o_valid), 64'(1));
            chk("latency_first", 64'(bus.o_first), 64'(1));
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_queue_empty", 64'(sb.size()), 64'(0));
        @(negedge clk);
    endtask

    task automatic make_random_block();
        for (int j = 0; j < K; j++) begin
            if ($urandom_range(0, 7) == 0) cur_blk[j] = 16'h0000;
            else cur_blk[j] = {1'($urandom_range(0, 1)), 8'($urandom_range(115, 135)), 7'($urandom)};
        end
    endtask

    // Output monitor: scoreboard pop on every accepted beat, plus hold/idle rules
    logic                     p_have;
    logic                     p_valid;
    logic                     p_ready;
    logic [LANES-1:0][BW-1:0] p_vec;
    logic [7:0]               p_exp;
    logic                     p_first;
    initial p_have = 1'b0;

    always @(negedge clk) begin
        beat_t it;
        if (!rst_n) begin
            p_have = 1'b0;
        end else begin
            if (p_have && p_valid && !p_ready) begin
                stall_seen++;
                chk("hold_valid", 64'(bus.o_valid), 64'(1));
                chk("hold_vec", 64'(bus.o_mx_vec), 64'(p_vec));
                chk("hold_exp", 64'(bus.o_mx_exp), 64'(p_exp));
                chk("hold_first", 64'(bus.o_first), 64'(p_first));
            end
            if (bus.o_valid) begin
                chk("ready_low_in_emit", 64'(bus.o_ready), 64'(0));
            end else begin
                chk("idle_outputs_zero", {bus.o_mx_vec[6:0], bus.o_mx_exp, bus.o_first}, 64'(0));
            end
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    it = sb.pop_front();
                    chk("beat_exp", 64'(bus.o_mx_exp), 64'(it.exp));
                    chk("beat_first", 64'(bus.o_first), 64'(it.first));
                    if (it.chk) chk("beat_vec", 64'(bus.o_mx_vec), 64'(it.vec));
                end
            end
            p_have  = 1'b1;
            p_valid = bus.o_valid;
            p_ready = bus.i_ready;
            p_vec   = bus.o_mx_vec;
            p_exp   = bus.o_mx_exp;
            p_first = bus.o_first;
        end
    end

    initial begin
        int guard;
        //             fill      s0       i0  s1       i1  exp    fill   s0     s1     chk
        tbl[0]  = '{16'h3F80, 16'h3F80, -1, 16'h0000, -1, 8'h7F, 8'h40, 8'h40, 8'h40, 1'b1};
        tbl[1]  = '{16'h3F80, 16'h4000,  0, 16'hBF80,  5, 8'h80, 8'h20, 8'h40, 8'hE0, 1'b1};
        tbl[2]  = '{16'h3F80, 16'hBF80,  5, 16'h0000, -1, 8'h7F, 8'h40, 8'hC0, 8'h00, 1'b1};
        tbl[3]  = '{16'h3F80, 16'h3CC0,  3, 16'hBCC0,  4, 8'h7F, 8'h40, R_P15, R_N15, 1'b1};
        tbl[4]  = '{16'h3F80, 16'h3FFF,  9, 16'h0000, -1, 8'h7F, 8'h40, 8'h7F, 8'h00, 1'b1};
        tbl[5]  = '{16'h3F80, 16'hBFFF, 31, 16'h0000, -1, 8'h7F, 8'h40, 8'h81, 8'h00, 1'b1};
        tbl[6]  = '{16'h3F80, 16'h7FC0, 12, 16'h0000, -1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7]  = '{16'h0000, 16'h0000, -1, 16'h0000, -1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[8]  = '{16'h8000, 16'h0000, -1, 16'h0000, -1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[9]  = '{16'h3F80, 16'h7F80, 20, 16'h0000, -1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{16'h3F80, 16'h0001,  7, 16'h0000, -1, 8'h7F, 8'h40, 8'h00, 8'h00, 1'b1};
        tbl[11] = '{16'h4700, 16'h3F80, 30, 16'h0000, -1, 8'h8E, 8'h40, 8'h00, 8'h00, 1'b1};
        tbl[12] = '{16'h3F80, 16'h3D20,  1, 16'h3D60,  2, 8'h7F, 8'h40, 8'h02, R_P35, 1'b1};

        rst_n          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_bf16_vec = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 64'(bus.o_valid), 64'(0));
        chk("reset_first", 64'(bus.o_first), 64'(0));
        chk("reset_exp", 64'(bus.o_mx_exp), 64'(0));
        chk("reset_vec", 64'(bus.o_mx_vec), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("reset_ready", 64'(bus.o_ready), 64'(1));

        // Directed blocks, back to back
        for (int n = 0; n < 13; n++) begin
            load_table(n);
            send_beats(BEATS, 1'b1);
        end
        drain();

        // Stall on output beat 1 while the next block waits on the input side
        fork
            begin
                make_random_block();
                push_model();
                send_beats(BEATS, 1'b1);
                make_random_block();
                push_model();
                send_beats(BEATS, 1'b1);
            end
            begin
                guard = 0;
                @(negedge clk);
                while (!(bus.o_valid && bus.o_first && bus.i_ready) && guard < 500) begin
                    @(negedge clk);
                    guard++;
                end
                chk("stall_beat0_seen", 64'(guard < 500), 64'(1));
                @(posedge clk);
                #1 stall_req = 1'b1;
                repeat (3) @(posedge clk);
                #1 stall_req = 1'b0;
            end
        join
        drain();
        chk("stall_cycles_seen", 64'(stall_seen >= 3), 64'(1));

        // Random data with random downstream backpressure
        rand_mode = 1'b1;
        for (int n = 0; n < 6; n++) begin
            make_random_block();
            push_model();
            send_beats(BEATS, 1'b1);
        end
        drain();
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Reset after two input beats discards the partial block
        make_random_block();
        send_beats(2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(bus.o_valid), 64'(0));
        chk("midreset_exp", 64'(bus.o_mx_exp), 64'(0));
        chk("midreset_vec", 64'(bus.o_mx_vec), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midreset_ready", 64'(bus.o_ready), 64'(1));
        load_table(1);
        send_beats(BEATS, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
